// File: rtl/rom_load_sequencer.sv
// ioctl download sequencer: routes HPS download bytes to ROM, mod-select and DIP targets,
// and keeps the core in reset until a ROM is loaded plus a fixed hold-off period.
module rom_load_sequencer #(
  parameter int HOLD_CYCLES = 1024,
  parameter int ROM_AW      = 16,
  parameter int NSW         = 8
) (
  input  logic              clk_sys,
  input  logic              RESET_N,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ext_reset,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic              rom_wr,
  output logic [7:0]        mod_sel,
  output logic [2:0]        sw_idx,
  output logic [7:0]        sw_data,
  output logic              sw_wr,
  output logic              core_reset,
  output logic              rom_loaded
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0]  HOLD_RELOAD = HCW'(HOLD_CYCLES - 1);
  localparam logic [ROM_AW:0] CNT_MAX     = {1'b1, {ROM_AW{1'b0}}};
  localparam logic [7:0]      IDX_ROM     = 8'd0;
  localparam logic [7:0]      IDX_MOD     = 8'd1;
  localparam logic [7:0]      IDX_DIP     = 8'd254;

  typedef enum logic [1:0] {
    S_WAIT_ROM = 2'd0,
    S_LOAD     = 2'd1,
    S_HOLD     = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [HCW-1:0]    hold_q, hold_d;
  logic [ROM_AW:0]   cnt_q, cnt_d;
  logic              loaded_q, loaded_d;
  logic              core_reset_q;

  logic              dl_prev_q;
  logic              dl_valid_q, dl_valid_d;
  logic [7:0]        idx_q, idx_d;

  logic              rom_wr_q, rom_wr_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        rom_data_q, rom_data_d;
  logic [7:0]        mod_sel_q, mod_sel_d;
  logic              sw_wr_q, sw_wr_d;
  logic [2:0]        sw_idx_q, sw_idx_d;
  logic [7:0]        sw_data_q, sw_data_d;

  logic              dl_rise_s;
  logic              dl_fall_s;
  logic              rise_rom_s;
  logic [7:0]        idx_eff_s;
  logic              wr_ok_s;
  logic              rom_in_range_s;
  logic              rom_acc_s;
  logic              mod_acc_s;
  logic              sw_acc_s;

  // dl_prev_q resets high so a download still held across RESET_N is not seen as a new rise.
  assign dl_rise_s      = ioctl_download & ~dl_prev_q;
  assign dl_fall_s      = ~ioctl_download & dl_prev_q;
  assign rise_rom_s     = dl_rise_s && (ioctl_index == IDX_ROM);
  assign idx_eff_s      = dl_rise_s ? ioctl_index : idx_q;
  assign wr_ok_s        = ioctl_wr && (dl_rise_s || dl_valid_q);
  assign rom_in_range_s = ((ioctl_addr >> ROM_AW) == 25'd0);
  assign rom_acc_s      = wr_ok_s && (idx_eff_s == IDX_ROM) && (state_q == S_LOAD) && rom_in_range_s;
  assign mod_acc_s      = wr_ok_s && (idx_eff_s == IDX_MOD);
  assign sw_acc_s       = wr_ok_s && (idx_eff_s == IDX_DIP) && (ioctl_addr < 25'(NSW));

  // Download tracking: latch the target index on the rise, stay valid through the fall cycle.
  always_comb begin
    idx_d      = idx_q;
    dl_valid_d = dl_valid_q;
    if (dl_rise_s) begin
      idx_d      = ioctl_index;
      dl_valid_d = 1'b1;
    end else if (dl_fall_s) begin
      dl_valid_d = 1'b0;
    end else begin
      dl_valid_d = dl_valid_q;
    end
  end

  // Write decode into one-cycle strobes and held data registers.
  always_comb begin
    rom_wr_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    mod_sel_d  = mod_sel_q;
    sw_wr_d    = 1'b0;
    sw_idx_d   = sw_idx_q;
    sw_data_d  = sw_data_q;
    if (rom_acc_s) begin
      rom_wr_d   = 1'b1;
      rom_addr_d = ioctl_addr[ROM_AW-1:0];
      rom_data_d = ioctl_dout;
    end else begin
      rom_wr_d = 1'b0;
    end
    if (mod_acc_s) begin
      mod_sel_d = ioctl_dout;
    end else begin
      mod_sel_d = mod_sel_q;
    end
    if (sw_acc_s) begin
      sw_wr_d   = 1'b1;
      sw_idx_d  = ioctl_addr[2:0];
      sw_data_d = ioctl_dout;
    end else begin
      sw_wr_d = 1'b0;
    end
  end

  // Sequencer next state; a write landing in the fall cycle still counts toward the load.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    loaded_d = loaded_q;
    if (rom_acc_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{ROM_AW{1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    case (state_q)
      S_WAIT_ROM: begin
        if (rise_rom_s) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          state_d = S_WAIT_ROM;
        end
      end
      S_LOAD: begin
        if (dl_fall_s) begin
          if ((cnt_q == '0) && !rom_acc_s) begin
            if (!loaded_q) begin
              state_d = S_WAIT_ROM;
            end else begin
              state_d = S_HOLD;
              hold_d  = HOLD_RELOAD;
            end
          end else begin
            state_d  = S_HOLD;
            hold_d   = HOLD_RELOAD;
            loaded_d = 1'b1;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_HOLD: begin
        if (rise_rom_s) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (ext_reset) begin
          hold_d = HOLD_RELOAD;
        end else if (hold_q == '0) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - HCW'(1);
        end
      end
      S_RUN: begin
        if (rise_rom_s) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (ext_reset) begin
          state_d = S_HOLD;
          hold_d  = HOLD_RELOAD;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_WAIT_ROM;
      end
    endcase
  end

  // Sequencer state, counters and core reset (registered alongside the state).
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_WAIT_ROM;
      hold_q       <= '0;
      cnt_q        <= '0;
      loaded_q     <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      loaded_q     <= loaded_d;
      core_reset_q <= (state_d != S_RUN);
    end
  end

  // Download edge tracking and index latch.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      dl_prev_q  <= 1'b1;
      dl_valid_q <= 1'b0;
      idx_q      <= 8'd0;
    end else begin
      dl_prev_q  <= ioctl_download;
      dl_valid_q <= dl_valid_d;
      idx_q      <= idx_d;
    end
  end

  // Output registers for the three download targets.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      rom_wr_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= 8'd0;
      mod_sel_q  <= 8'd0;
      sw_wr_q    <= 1'b0;
      sw_idx_q   <= 3'd0;
      sw_data_q  <= 8'd0;
    end else begin
      rom_wr_q   <= rom_wr_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      mod_sel_q  <= mod_sel_d;
      sw_wr_q    <= sw_wr_d;
      sw_idx_q   <= sw_idx_d;
      sw_data_q  <= sw_data_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign rom_wr     = rom_wr_q;
  assign mod_sel    = mod_sel_q;
  assign sw_idx     = sw_idx_q;
  assign sw_data    = sw_data_q;
  assign sw_wr      = sw_wr_q;
  assign core_reset = core_reset_q;
  assign rom_loaded = loaded_q;

endmodule
